// File: rtl/lift_pkg.sv
// rtl/lift_pkg.sv - shared state encoding and width helper for the SCAN lift controller
package lift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } lift_state_e;

    function automatic int lift_clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/lift_req_latch.sv
// rtl/lift_req_latch.sv - per-floor request set/clear register, clear wins over set
module lift_req_latch #(
    parameter int           N    = 4,
    parameter logic [N-1:0] MASK = '1
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic [N-1:0] set_i,
    input  logic [N-1:0] clr_i,
    output logic [N-1:0] pend_o
);

    logic [N-1:0] pend_q;
    logic [N-1:0] pend_d;

    always_comb begin
        pend_d = (pend_q | set_i) & ~clr_i & MASK;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) pend_q <= '0;
        else         pend_q <= pend_d;
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/lift_scan_ctrl.sv
// rtl/lift_scan_ctrl.sv - N-floor SCAN lift dispatcher with latched requests and timed door
module lift_scan_ctrl
    import lift_pkg::*;
#(
    parameter int NFLOORS   = 4,
    parameter int FLW       = 2,
    parameter int TRAVEL_TC = 10,
    parameter int DOOR_TC   = 5
) (
    input  logic               clk,
    input  logic               resetb,
    input  logic               slowref,
    input  logic [NFLOORS-1:0] car_req,
    input  logic [NFLOORS-1:0] hall_up,
    input  logic [NFLOORS-1:0] hall_dn,
    output logic [NFLOORS-1:0] car_pend,
    output logic [NFLOORS-1:0] up_pend,
    output logic [NFLOORS-1:0] dn_pend,
    output logic [FLW-1:0]     floorno,
    output logic               upsig,
    output logic               dnsig,
    output logic               moving,
    output logic               door_open
);

    localparam int CTR_MAX = (TRAVEL_TC > DOOR_TC) ? TRAVEL_TC : DOOR_TC;
    localparam int CW      = lift_clog2(CTR_MAX + 1);
    localparam logic [NFLOORS-1:0] UP_MASK  = {1'b0, {(NFLOORS-1){1'b1}}};
    localparam logic [NFLOORS-1:0] DN_MASK  = {{(NFLOORS-1){1'b1}}, 1'b0};
    localparam logic [NFLOORS-1:0] ALL_MASK = '1;

    lift_state_e       state_q;
    logic [FLW-1:0]    floorno_q;
    logic              dir_q;
    logic [CW-1:0]     ctr_q;

    logic [NFLOORS-1:0] all_pend, floor_oh, nf_oh, door_sup;
    logic [NFLOORS-1:0] up_in, dn_in;
    logic [NFLOORS-1:0] car_set, up_set, dn_set, car_clr, up_clr, dn_clr;
    logic [FLW-1:0]     nf;
    logic               any_above, any_below, here, beyond_nf, at_end, stop;
    logic               press_here, idle_serve, arrive_stop, travel_done;

    assign all_pend    = car_pend | up_pend | dn_pend;
    assign up_in       = hall_up & UP_MASK;
    assign dn_in       = hall_dn & DN_MASK;
    assign travel_done = (ctr_q == CW'(TRAVEL_TC));

    // nf saturates at the shaft ends so the car can never be driven past them
    always_comb begin
        nf = floorno_q;
        if (dir_q && floorno_q != FLW'(NFLOORS - 1)) nf = floorno_q + FLW'(1);
        if (!dir_q && floorno_q != '0)               nf = floorno_q - FLW'(1);
    end

    always_comb begin
        floor_oh  = '0;
        nf_oh     = '0;
        any_above = 1'b0;
        any_below = 1'b0;
        beyond_nf = 1'b0;
        for (int f = 0; f < NFLOORS; f++) begin
            floor_oh[f] = (FLW'(f) == floorno_q);
            nf_oh[f]    = (FLW'(f) == nf);
            if (FLW'(f) > floorno_q) any_above = any_above | all_pend[f];
            if (FLW'(f) < floorno_q) any_below = any_below | all_pend[f];
            if (dir_q ? (FLW'(f) > nf) : (FLW'(f) < nf)) beyond_nf = beyond_nf | all_pend[f];
        end
    end

    assign here   = |(all_pend & floor_oh);
    assign at_end = dir_q ? (nf == FLW'(NFLOORS - 1)) : (nf == '0);
    assign stop   = |(car_pend & nf_oh) | |((dir_q ? up_pend : dn_pend) & nf_oh) | !beyond_nf | at_end;

    // A press at the open-door floor extends the door instead of being latched
    assign door_sup   = (state_q == ST_DOOR) ? floor_oh : '0;
    assign press_here = |(door_sup & (car_req | up_in | dn_in));
    assign car_set    = car_req & ~door_sup;
    assign up_set     = up_in & ~door_sup;
    assign dn_set     = dn_in & ~door_sup;

    assign idle_serve  = slowref && (state_q == ST_IDLE) && here;
    assign arrive_stop = slowref && (state_q == ST_MOVE) && travel_done && stop;

    always_comb begin
        car_clr = '0;
        up_clr  = '0;
        dn_clr  = '0;
        if (idle_serve) begin
            car_clr = floor_oh;
            up_clr  = floor_oh;
            dn_clr  = floor_oh;
        end else if (arrive_stop) begin
            car_clr = nf_oh;
            if (dir_q || !beyond_nf)  up_clr = nf_oh;
            if (!dir_q || !beyond_nf) dn_clr = nf_oh;
        end
    end

    lift_req_latch #(.N(NFLOORS), .MASK(ALL_MASK)) u_car (
        .clk(clk), .resetb(resetb), .set_i(car_set), .clr_i(car_clr), .pend_o(car_pend));
    lift_req_latch #(.N(NFLOORS), .MASK(UP_MASK)) u_up (
        .clk(clk), .resetb(resetb), .set_i(up_set), .clr_i(up_clr), .pend_o(up_pend));
    lift_req_latch #(.N(NFLOORS), .MASK(DN_MASK)) u_dn (
        .clk(clk), .resetb(resetb), .set_i(dn_set), .clr_i(dn_clr), .pend_o(dn_pend));

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= ST_IDLE;
            floorno_q <= '0;
            dir_q     <= 1'b1;
            ctr_q     <= '0;
        end else if (press_here) begin
            ctr_q <= '0;
        end else if (slowref) begin
            case (state_q)
                ST_IDLE: begin
                    ctr_q <= '0;
                    if (here) begin
                        state_q <= ST_DOOR;
                    end else if (any_above && (dir_q || !any_below)) begin
                        dir_q   <= 1'b1;
                        state_q <= ST_MOVE;
                    end else if (any_below) begin
                        dir_q   <= 1'b0;
                        state_q <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    if (travel_done) begin
                        floorno_q <= nf;
                        ctr_q     <= '0;
                        if (stop) state_q <= ST_DOOR;
                    end else begin
                        ctr_q <= ctr_q + CW'(1);
                    end
                end
                ST_DOOR: begin
                    if (ctr_q == CW'(DOOR_TC)) begin
                        ctr_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        ctr_q <= ctr_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ctr_q   <= '0;
                end
            endcase
        end
    end

    assign floorno   = floorno_q;
    assign moving    = (state_q == ST_MOVE);
    assign door_open = (state_q == ST_DOOR);
    assign upsig     = moving & dir_q;
    assign dnsig     = moving & ~dir_q;

endmodule

// File: tb/tb_lift_scan_ctrl.sv
// tb/tb_lift_scan_ctrl.sv - self-checking bench for lift_scan_ctrl with a behavioural SCAN model
module tb_lift_scan_ctrl;

    localparam int NF = 4;
    localparam int TT = 3;
    localparam int DT = 2;

    logic          clk = 1'b0;
    logic          resetb = 1'b0;
    logic          slowref = 1'b0;
    logic [NF-1:0] car_req = '0, hall_up = '0, hall_dn = '0;
    logic [NF-1:0] car_pend, up_pend, dn_pend;
    logic [1:0]    floorno;
    logic          upsig, dnsig, moving, door_open;

    int  n_tests = 0;
    int  n_fails = 0;
    bit  slow_en = 1'b0;
    bit  phase = 1'b0;

    lift_scan_ctrl #(.NFLOORS(NF), .FLW(2), .TRAVEL_TC(TT), .DOOR_TC(DT)) dut (
        .clk(clk), .resetb(resetb), .slowref(slowref),
        .car_req(car_req), .hall_up(hall_up), .hall_dn(hall_dn),
        .car_pend(car_pend), .up_pend(up_pend), .dn_pend(dn_pend),
        .floorno(floorno), .upsig(upsig), .dnsig(dnsig),
        .moving(moving), .door_open(door_open));

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            slowref = slow_en && phase;
            phase   = ~phase;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: the car as a floor number, a mode and a pending list
    bit [NF-1:0] m_car, m_up, m_dn;
    int  m_floor, m_mode, m_ticks;
    bit  m_goes_up;

    function automatic bit wanted(input int f);
        return m_car[f] | m_up[f] | m_dn[f];
    endfunction

    function automatic bit wanted_past(input int f, input bit up);
        for (int g = 0; g < NF; g++)
            if ((up ? (g > f) : (g < f)) && wanted(g)) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge resetb) begin
        bit [NF-1:0] sc, su, sd, cc, cu, cd;
        bit press, past, halt;
        int nxt;
        if (!resetb) begin
            m_car = '0; m_up = '0; m_dn = '0;
            m_floor = 0; m_mode = 0; m_ticks = 0; m_goes_up = 1'b1;
        end else begin
            sc = car_req; su = hall_up & 4'b0111; sd = hall_dn & 4'b1110;
            cc = '0; cu = '0; cd = '0;
            press = 1'b0;
            if (m_mode == 2) begin
                press = sc[m_floor] | su[m_floor] | sd[m_floor];
                sc[m_floor] = 1'b0; su[m_floor] = 1'b0; sd[m_floor] = 1'b0;
            end
            if (slowref && !press) begin
                if (m_mode == 0) begin
                    if (wanted(m_floor)) begin
                        cc[m_floor] = 1'b1; cu[m_floor] = 1'b1; cd[m_floor] = 1'b1;
                        m_mode = 2;
                    end else if (wanted_past(m_floor, 1'b1) && (m_goes_up || !wanted_past(m_floor, 1'b0))) begin
                        m_goes_up = 1'b1; m_mode = 1;
                    end else if (wanted_past(m_floor, 1'b0)) begin
                        m_goes_up = 1'b0; m_mode = 1;
                    end
                    m_ticks = 0;
                end else if (m_mode == 1) begin
                    if (m_ticks == TT) begin
                        nxt  = m_goes_up ? m_floor + 1 : m_floor - 1;
                        past = wanted_past(nxt, m_goes_up);
                        halt = m_car[nxt] || (m_goes_up ? m_up[nxt] : m_dn[nxt]) || !past
                               || nxt == 0 || nxt == NF - 1;
                        m_floor = nxt;
                        m_ticks = 0;
                        if (halt) begin
                            cc[nxt] = 1'b1;
                            if (m_goes_up || !past)  cu[nxt] = 1'b1;
                            if (!m_goes_up || !past) cd[nxt] = 1'b1;
                            m_mode = 2;
                        end
                    end else begin
                        m_ticks++;
                    end
                end else begin
                    if (m_ticks == DT) begin m_mode = 0; m_ticks = 0; end
                    else m_ticks++;
                end
            end
            if (press) m_ticks = 0;
            m_car = (m_car | sc) & ~cc;
            m_up  = (m_up | su) & ~cu;
            m_dn  = (m_dn | sd) & ~cd;
        end
    end

    always @(negedge clk) begin
        chk("model car_pend", car_pend, m_car);
        chk("model up_pend", up_pend, m_up);
        chk("model dn_pend", dn_pend, m_dn);
        chk("model floorno", floorno, m_floor);
        chk("model moving", moving, m_mode == 1);
        chk("model door_open", door_open, m_mode == 2);
        chk("model upsig", upsig, (m_mode == 1) && m_goes_up);
        chk("model dnsig", dnsig, (m_mode == 1) && !m_goes_up);
    end

    task automatic pulse(input logic [NF-1:0] c, input logic [NF-1:0] u, input logic [NF-1:0] d);
        @(posedge clk); #2;
        car_req = c; hall_up = u; hall_dn = d;
        @(posedge clk); #2;
        car_req = '0; hall_up = '0; hall_dn = '0;
    endtask

    // kind 0: door open, 1: settled idle, 2: moving at floor arg, 3: door closed
    task automatic wait_for(input int kind, input int arg, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            case (kind)
                0: ok = door_open;
                1: ok = !moving && !door_open && car_pend == 0 && up_pend == 0 && dn_pend == 0;
                2: ok = moving && floorno == arg[1:0];
                default: ok = !door_open;
            endcase
        end
        chk({"timeout ", name}, ok, 1);
    endtask

    // counts slowref ticks while the selected output stays high
    task automatic count_ticks(input int kind, output int n);
        bit hi;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            hi = (kind == 0) ? upsig : door_open;
            if (!hi) break;
            if (slowref) n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2;
        chk("reset floorno", floorno, 0);
        chk("reset pend", {car_pend, up_pend, dn_pend}, 0);
        chk("reset outputs", {upsig, dnsig, moving, door_open}, 0);
        resetb = 1'b1;
        slow_en = 1'b1;

        pulse(4'b0000, 4'b1000, 4'b0001);
        repeat (10) @(negedge clk);
        chk("masked up_pend", up_pend, 0);
        chk("masked dn_pend", dn_pend, 0);
        chk("masked idle", {moving, door_open, 2'(floorno)}, 0);

        pulse(4'b1000, 4'b0000, 4'b0000);
        @(negedge clk);
        chk("s1 car_pend", car_pend, 4'b1000);
        wait_for(2, 0, "s1 start");
        count_ticks(0, n);
        chk("s1 up ticks", n, 12);
        chk("s1 arrive floor", floorno, 3);
        chk("s1 car_pend clr", car_pend, 0);
        count_ticks(1, n);
        chk("s1 door ticks", n, 3);

        pulse(4'b0001, 4'b0000, 4'b0100);
        wait_for(0, 0, "s2 door2");
        chk("s2 floor", floorno, 2);
        chk("s2 dn_pend", dn_pend, 0);
        chk("s2 car_pend", car_pend, 4'b0001);
        wait_for(3, 0, "s2 close2");
        wait_for(0, 0, "s2 door0");
        chk("s2 floor0", floorno, 0);
        wait_for(1, 0, "s2 idle");
        chk("s2 dnsig", dnsig, 0);

        pulse(4'b1000, 4'b0000, 4'b0000);
        wait_for(2, 1, "s3 pass1");
        pulse(4'b0000, 4'b0000, 4'b0010);
        wait_for(0, 0, "s3 door3");
        chk("s3 floor3", floorno, 3);
        chk("s3 dn_pend held", dn_pend, 4'b0010);
        wait_for(3, 0, "s3 close3");
        wait_for(0, 0, "s3 door1");
        chk("s3 floor1", floorno, 1);
        chk("s3 dn_pend clr", dn_pend, 0);
        wait_for(1, 0, "s3 idle");

        pulse(4'b0100, 4'b0000, 4'b0000);
        wait_for(0, 0, "s5 door2");
        n = 0;
        for (int i = 0; i < 50 && n < 2; i++) begin
            if (slowref && door_open) n++;
            if (n < 2) @(negedge clk);
        end
        pulse(4'b0100, 4'b0000, 4'b0000);
        @(negedge clk);
        chk("s5 car_pend stays", car_pend, 0);
        chk("s5 door held", door_open, 1);
        count_ticks(1, n);
        chk("s5 door ticks", n, 3);

        pulse(4'b0001, 4'b0000, 4'b0000);
        wait_for(2, 2, "s6 move");
        repeat (3) @(negedge clk);
        slow_en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        resetb = 1'b0;
        #1;
        chk("s6 rst floorno", floorno, 0);
        chk("s6 rst pend", {car_pend, up_pend, dn_pend}, 0);
        chk("s6 rst outputs", {upsig, dnsig, moving, door_open}, 0);
        repeat (3) @(posedge clk);
        #2;
        resetb = 1'b1;
        slow_en = 1'b1;
        repeat (20) @(negedge clk);
        chk("s6 stays idle", {moving, door_open, 2'(floorno)}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
